pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch controller for the RV32I single-cycle core. Owns the architectural PC register and sequences instruction fetch over a single-outstanding request/ready memory handshake.
- Presents each fetched instruction to decode and holds it while decode stalls.
- Applies next-PC selection on instruction consumption: sequential, branch/jump redirect, trap, or halt.
- Sits between the instruction memory and the decode/execute datapath; replaces the free-running program counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and data width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  XLEN  fetch address; equals pc, stable while imem_req is high.
- imem_ready  in  1  response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr and instr_pc are valid for decode.
- instr  out  32  registered instruction word.
- instr_pc  out  XLEN  address of instr.
- stall  in  1  decode cannot accept; consume = instr_valid & !stall.
- redirect_valid  in  1  branch/jump taken by the consumed instruction.
- redirect_target  in  XLEN  redirect destination.
- trap  in  1  consumed instruction raises an exception.
- trap_vector  in  XLEN  trap handler base; bits [1:0] are ignored.
- halt  in  1  consumed instruction is EBREAK; stop fetching.
- epc  out  XLEN  PC of the last trapping or misaligned instruction.
- misalign_err  out  1  one-cycle pulse when a misaligned redirect is taken.
- halted  out  1  sequencer stopped.
- instret  out  32  count of consumed instructions.

Behaviour:
- Reset values (rst sampled high on an edge):
  - pc = RESET_VECTOR; state = S_BOOT.
  - imem_req = 0; instr_valid = 0; instr = 0; instr_pc = 0.
  - epc = 0; misalign_err = 0; halted = 0; instret = 0.
  - imem_addr = pc throughout.
  - rst has priority over every other input in every state; it abandons any outstanding fetch, and the response is dropped.
- FSM states: S_BOOT, S_FETCH, S_ISSUE, S_HALT.
- S_BOOT:
  - Lasts one cycle with imem_req = 0; next state S_FETCH.
- S_FETCH:
  - imem_req = 1 and imem_addr = pc.
  - On imem_ready: instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1, next state S_ISSUE.
  - With zero-wait memory, instr_valid rises 1 cycle after the request is first asserted.
- S_ISSUE:
  - imem_req = 0; instr_valid = 1 and instr is held stable while stall = 1.
  - redirect_valid, trap and halt are sampled only in the consume cycle and ignored in every other cycle.
  - On consume, instret <= instret + 1 (wraps 0xFFFF_FFFF -> 0), then the first matching rule applies:
    1. trap: epc <= instr_pc; pc <= {trap_vector[31:2], 2'b00}; next state S_FETCH.
    2. redirect_valid with redirect_target[1:0] != 0: treated as a misaligned-fetch trap. epc <= instr_pc; pc <= trap-vector base; misalign_err pulses high for the next cycle only; next state S_FETCH.
    3. redirect_valid (aligned): pc <= redirect_target; next state S_FETCH.
    4. halt: next state S_HALT; pc <= instr_pc + 4.
    5. Otherwise: pc <= instr_pc + 4; next state S_FETCH.
  - instr_valid drops the cycle after consume.
  - Exactly one fetch is outstanding per instruction, so issue throughput is at most one instruction per 2 cycles. This is accepted for the single-cycle core.
- S_HALT:
  - halted = 1; imem_req = 0; instr_valid = 0.
  - Only rst exits this state; all other inputs are ignored.
- Arithmetic:
  - pc + 4 is modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000 with no error.
  - pc is always word-aligned; RESET_VECTOR[1:0] must be 0, enforced by an elaboration assertion.
- Simultaneous events: trap, redirect and halt together are resolved by the priority order above. Halt is lost if trap or redirect wins.

Decomposition:
- Package rv32_pkg holds:
  - the state enum typedef pc_state_e;
  - the constants PC_STEP = 4 and TRAP_ALIGN_MASK = 32'hFFFF_FFFC.
- One sub-module is natural: pc_next_sel. It is purely combinational next-PC and priority selection, with outputs next_pc, take_trap, take_misalign and go_halt. The FSM and all registers stay in pc_sequencer.

Test Plan:
- Reset then sequential run, zero-wait memory, stall = 0:
  - imem_addr sequence is 0x0, 0x4, 0x8, …
  - instr_valid rises 1 cycle after each request; instret = 3 after three consumes.
- Memory wait of 3 cycles at pc = 0x8:
  - imem_req and imem_addr = 0x8 stay stable for 4 cycles.
  - instr_valid = 0 throughout, then the instruction issues with instr_pc = 0x8.
- stall held 5 cycles in S_ISSUE:
  - instr and instr_pc are unchanged, no new imem_req, and instret does not increment until stall drops.
- Consume at instr_pc = 0x10 with redirect_valid = 1, redirect_target = 0x40:
  - next imem_addr = 0x40.
- Same with redirect_target = 0x42, trap_vector = 0x103:
  - epc = 0x10 and misalign_err pulses for 1 cycle; next imem_addr = 0x100.
- trap and halt asserted together at instr_pc = 0x20:
  - trap wins: epc = 0x20, fetch from the trap-vector base, halted stays 0.
- Later halt alone: halted = 1 and no further imem_req.
- rst mid-wait (imem_req high at 0x24):
  - next cycle imem_req = 0 and pc = RESET_VECTOR; a late imem_ready is ignored.

Source files
------------

// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared types and constants for the RV32I fetch path.
//   pc_state_e      : fetch sequencer states (boot, fetch, issue, halt)
//   PC_STEP         : byte distance between consecutive instructions
//   TRAP_ALIGN_MASK : clears the low two bits of a trap vector to get its base
// ----------------------------------------------------------------------------
package rv32_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] TRAP_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC selection for the instruction being consumed.
// Priority: trap, misaligned redirect, aligned redirect, halt, sequential.
// Ports:
//   instr_pc        in  32  address of the instruction being consumed
//   redirect_valid  in   1  branch/jump taken
//   redirect_target in  32  branch/jump destination
//   trap            in   1  instruction raises an exception
//   trap_vector     in  32  trap handler base (low two bits ignored)
//   halt            in   1  instruction is EBREAK
//   next_pc         out 32  PC to fetch next (or park at when halting)
//   take_trap       out  1  trap rule won
//   take_misalign   out  1  misaligned redirect rule won
//   go_halt         out  1  halt rule won
// ----------------------------------------------------------------------------
module pc_next_sel
    import rv32_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic [31:0] trap_vector,
    input  logic        halt,
    output logic [31:0] next_pc,
    output logic        take_trap,
    output logic        take_misalign,
    output logic        go_halt
);

    logic [31:0] trapBase;
    logic        targetMisaligned;

    assign trapBase         = trap_vector & TRAP_ALIGN_MASK;
    assign targetMisaligned = (redirect_target[1:0] != 2'b00);

    // A misaligned redirect is turned into a trap to the same handler base,
    // so a halt on the same instruction is dropped whenever trap or redirect wins.
    always_comb begin
        next_pc       = instr_pc + PC_STEP;
        take_trap     = 1'b0;
        take_misalign = 1'b0;
        go_halt       = 1'b0;
        if (trap) begin
            take_trap = 1'b1;
            next_pc   = trapBase;
        end else if (redirect_valid && targetMisaligned) begin
            take_misalign = 1'b1;
            next_pc       = trapBase;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (halt) begin
            go_halt = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Fetch controller for the RV32I single-cycle core. Owns the PC, issues one
// outstanding fetch at a time, holds the fetched instruction for decode until
// it is consumed, then applies the next-PC rules.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/addr/ready/rdata     instruction memory request/ready handshake
//   instr_valid/instr/instr_pc    instruction presented to decode
//   stall                         decode back-pressure (consume = valid & !stall)
//   redirect_valid/target         taken branch/jump of the consumed instruction
//   trap/trap_vector              exception of the consumed instruction
//   halt                          EBREAK of the consumed instruction
//   epc, misalign_err, halted     exception PC, misaligned-redirect pulse, stopped
//   instret                       consumed instruction count (wraps)
// ----------------------------------------------------------------------------
module pc_sequencer
    import rv32_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err,
    output logic            halted,
    output logic [31:0]     instret
);

    if (XLEN != 32) begin : g_xlenCheck
        $error("pc_sequencer: only XLEN = 32 is supported");
    end

    if (RESET_VECTOR[1:0] != 2'b00) begin : g_resetAlignCheck
        $error("pc_sequencer: RESET_VECTOR must be word aligned");
    end

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            imemReq_q;
    logic            instrValid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instrPc_q;
    logic [XLEN-1:0] epc_q;
    logic            misalignErr_q;
    logic            halted_q;
    logic [31:0]     instret_q;

    logic [31:0]     instret_d;
    logic [XLEN-1:0] pc_d;
    logic            consume;
    logic            takeTrap;
    logic            takeMisalign;
    logic            goHalt;

    // instr_valid is only ever high while issuing, so it doubles as the state qualifier.
    assign consume   = instrValid_q & ~stall;
    assign instret_d = instret_q + 32'd1;

    pc_next_sel u_nextSel (
        .instr_pc        (instrPc_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .trap_vector     (trap_vector),
        .halt            (halt),
        .next_pc         (pc_d),
        .take_trap       (takeTrap),
        .take_misalign   (takeMisalign),
        .go_halt         (goHalt)
    );

    // Single sequencer FSM. All outputs are registered and set on the
    // transition into the state that owns them, so imem_req is high exactly
    // while fetching and instr_valid exactly while issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            imemReq_q     <= 1'b0;
            instrValid_q  <= 1'b0;
            instr_q       <= 32'd0;
            instrPc_q     <= {XLEN{1'b0}};
            epc_q         <= {XLEN{1'b0}};
            misalignErr_q <= 1'b0;
            halted_q      <= 1'b0;
            instret_q     <= 32'd0;
        end else begin
            misalignErr_q <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    state_q   <= S_FETCH;
                    imemReq_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q      <= imem_rdata;
                        instrPc_q    <= pc_q;
                        instrValid_q <= 1'b1;
                        imemReq_q    <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (consume) begin
                        instret_q    <= instret_d;
                        instrValid_q <= 1'b0;
                        pc_q         <= pc_d;
                        if (takeTrap || takeMisalign) begin
                            epc_q <= instrPc_q;
                        end
                        if (takeMisalign) begin
                            misalignErr_q <= 1'b1;
                        end
                        if (goHalt) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q   <= S_FETCH;
                            imemReq_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_req     = imemReq_q;
    assign imem_addr    = pc_q;
    assign instr_valid  = instrValid_q;
    assign instr        = instr_q;
    assign instr_pc     = instrPc_q;
    assign epc          = epc_q;
    assign misalign_err = misalignErr_q;
    assign halted       = halted_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a directed walk through fetch, memory
// wait, stall, redirect, misaligned redirect, trap/halt priority, reset during
// a fetch and PC wrap, followed by a randomized run. A transaction-level model
// of the fetch/issue behaviour is compared against every output each cycle.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        halt;
    logic [31:0] epc;
    logic        misalign_err;
    logic        halted;
    logic [31:0] instret;

    int compared   = 0;
    int mismatched = 0;
    bit useRandData = 0;

    // Behavioural model: what the fetch unit is doing, in plain terms.
    bit          mLive     = 0;
    bit          mBooting  = 0;
    bit          mWaiting  = 0;
    bit          mHolding  = 0;
    bit          mStopped  = 0;
    bit          mMisPulse = 0;
    logic [31:0] mPc       = 0;
    logic [31:0] mInstr    = 0;
    logic [31:0] mInstrPc  = 0;
    logic [31:0] mEpc      = 0;
    logic [31:0] mInstret  = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .trap_vector     (trap_vector),
        .halt            (halt),
        .epc             (epc),
        .misalign_err    (misalign_err),
        .halted          (halted),
        .instret         (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrWord(input logic [31:0] addr);
        return 32'hA500_0000 ^ addr;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to the next falling edge and present memory data for the
    // address currently requested.
    task automatic step();
        @(negedge clk);
        imem_rdata = useRandData ? $urandom : instrWord(imem_addr);
    endtask

    task automatic waitReq(input logic [31:0] addr, input string name);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        if (!imem_req) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: imem_req never rose, expected addr 0x%08h", name, addr);
        end else begin
            checkOutput(name, imem_addr, addr);
        end
    endtask

    task automatic waitValid(input logic [31:0] pc, input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        if (!instr_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: instr_valid never rose, expected pc 0x%08h", name, pc);
        end else begin
            checkOutput(name, instr_pc, pc);
            checkOutput({name, "_instr"}, instr, useRandData ? mInstr : instrWord(pc));
        end
    endtask

    task automatic applyStimulus();
        rst             = (($urandom % 100) == 0);
        imem_ready      = 1'($urandom % 2);
        stall           = (($urandom % 10) < 3);
        redirect_valid  = (($urandom % 10) < 2);
        redirect_target = (($urandom % 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
        trap            = (($urandom % 20) == 0);
        trap_vector     = $urandom;
        halt            = (($urandom % 30) == 0);
    endtask

    // Model update on each rising edge from the inputs presented this cycle.
    task automatic modelStep();
        logic [31:0] handler;
        if (rst) begin
            mLive = 1; mBooting = 1; mWaiting = 0; mHolding = 0; mStopped = 0;
            mMisPulse = 0; mPc = 0; mInstr = 0; mInstrPc = 0; mEpc = 0; mInstret = 0;
            return;
        end
        if (!mLive) return;
        handler   = trap_vector & ~32'h3;
        mMisPulse = 0;
        if (mBooting) begin
            mBooting = 0;
            mWaiting = 1;
        end else if (mWaiting) begin
            if (imem_ready) begin
                mInstr   = imem_rdata;
                mInstrPc = mPc;
                mWaiting = 0;
                mHolding = 1;
            end
        end else if (mHolding && !stall) begin
            mInstret = mInstret + 1;
            mHolding = 0;
            if (trap) begin
                mEpc = mInstrPc; mPc = handler; mWaiting = 1;
            end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                mEpc = mInstrPc; mPc = handler; mMisPulse = 1; mWaiting = 1;
            end else if (redirect_valid) begin
                mPc = redirect_target; mWaiting = 1;
            end else if (halt) begin
                mPc = mInstrPc + 4; mStopped = 1;
            end else begin
                mPc = mInstrPc + 4; mWaiting = 1;
            end
        end
    endtask

    always @(posedge clk) modelStep();

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin
        if (mLive) begin
            checkOutput("imem_req",     32'(imem_req),     32'(mWaiting));
            checkOutput("imem_addr",    imem_addr,         mPc);
            checkOutput("instr_valid",  32'(instr_valid),  32'(mHolding));
            checkOutput("instr",        instr,             mInstr);
            checkOutput("instr_pc",     instr_pc,          mInstrPc);
            checkOutput("epc",          epc,               mEpc);
            checkOutput("misalign_err", 32'(misalign_err), 32'(mMisPulse));
            checkOutput("halted",       32'(halted),       32'(mStopped));
            checkOutput("instret",      instret,           mInstret);
        end
    end

    initial begin
        rst = 1; imem_ready = 1; imem_rdata = 0; stall = 0; redirect_valid = 0;
        redirect_target = 0; trap = 0; trap_vector = 32'h103; halt = 0;
        step();
        step();
        checkOutput("rst_req",     32'(imem_req),    32'd0);
        checkOutput("rst_addr",    imem_addr,        32'h0);
        checkOutput("rst_valid",   32'(instr_valid), 32'd0);
        checkOutput("rst_instret", instret,          32'd0);
        checkOutput("rst_halted",  32'(halted),      32'd0);
        checkOutput("rst_epc",     epc,              32'h0);
        rst = 0;

        // Sequential run with zero-wait memory.
        waitReq(32'h0, "seq_addr0");
        step();
        checkOutput("seq_valid0", 32'(instr_valid), 32'd1);
        waitValid(32'h0, "seq_pc0");
        waitReq(32'h4, "seq_addr4");
        step();
        checkOutput("seq_valid4", 32'(instr_valid), 32'd1);
        waitValid(32'h4, "seq_pc4");

        // Memory answers three cycles late at 0x8.
        imem_ready = 0;
        waitReq(32'h8, "wait_addr8");
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("wait_req",   32'(imem_req),    32'd1);
            checkOutput("wait_addr",  imem_addr,        32'h8);
            checkOutput("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1;
        step();
        waitValid(32'h8, "wait_pc8");

        // Decode stalls for five cycles on 0x8.
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_valid",   32'(instr_valid), 32'd1);
            checkOutput("stall_pc",      instr_pc,         32'h8);
            checkOutput("stall_instr",   instr,            instrWord(32'h8));
            checkOutput("stall_req",     32'(imem_req),    32'd0);
            checkOutput("stall_instret", instret,          32'd2);
        end
        stall = 0;
        step();
        checkOutput("seq_instret3", instret,   32'd3);
        checkOutput("seq_addrC",    imem_addr, 32'hC);
        waitValid(32'hC, "seq_pcC");
        step();
        waitValid(32'h10, "seq_pc10");

        // Aligned redirect to 0x40, then back to 0x10.
        redirect_valid = 1; redirect_target = 32'h40;
        step();
        redirect_valid = 0;
        checkOutput("redir_req",  32'(imem_req), 32'd1);
        checkOutput("redir_addr", imem_addr,     32'h40);
        waitValid(32'h40, "redir_pc40");
        redirect_valid = 1; redirect_target = 32'h10;
        step();
        redirect_valid = 0;
        waitValid(32'h10, "redir_pc10");

        // Misaligned redirect becomes a trap to the vector base.
        redirect_valid = 1; redirect_target = 32'h42;
        step();
        redirect_valid = 0;
        checkOutput("mis_epc",   epc,               32'h10);
        checkOutput("mis_pulse", 32'(misalign_err), 32'd1);
        checkOutput("mis_addr",  imem_addr,         32'h100);
        step();
        checkOutput("mis_pulse_end", 32'(misalign_err), 32'd0);
        waitValid(32'h100, "mis_pc100");

        // Trap and halt together: trap wins.
        redirect_valid = 1; redirect_target = 32'h20;
        step();
        redirect_valid = 0;
        waitValid(32'h20, "th_pc20");
        trap = 1; halt = 1;
        step();
        trap = 0; halt = 0;
        checkOutput("th_epc",    epc,          32'h20);
        checkOutput("th_addr",   imem_addr,    32'h100);
        checkOutput("th_halted", 32'(halted),  32'd0);
        checkOutput("th_req",    32'(imem_req), 32'd1);
        waitValid(32'h100, "th_pc100");

        // Halt alone stops fetching for good.
        halt = 1;
        step();
        halt = 0;
        checkOutput("halt_halted", 32'(halted),   32'd1);
        checkOutput("halt_req",    32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("halt_stay_req",   32'(imem_req),    32'd0);
            checkOutput("halt_stay_valid", 32'(instr_valid), 32'd0);
        end

        // Reset while a fetch to 0x24 is outstanding; the late response is dropped.
        rst = 1;
        step();
        rst = 0;
        waitReq(32'h0, "rr_addr0");
        step();
        waitValid(32'h0, "rr_pc0");
        imem_ready = 0; redirect_valid = 1; redirect_target = 32'h24;
        step();
        redirect_valid = 0;
        checkOutput("rr_req24",  32'(imem_req), 32'd1);
        checkOutput("rr_addr24", imem_addr,     32'h24);
        step();
        rst = 1;
        step();
        checkOutput("rr_req_off", 32'(imem_req),    32'd0);
        checkOutput("rr_pc_rv",   imem_addr,        32'h0);
        checkOutput("rr_valid",   32'(instr_valid), 32'd0);
        rst = 0; imem_ready = 1;
        step();
        checkOutput("rr_late_valid", 32'(instr_valid), 32'd0);
        checkOutput("rr_boot_req",   32'(imem_req),    32'd1);
        checkOutput("rr_boot_addr",  imem_addr,        32'h0);
        step();
        waitValid(32'h0, "rr_pc0b");

        // PC wraps from the top of the address space to zero.
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 0;
        waitValid(32'hFFFF_FFFC, "wrap_pcTop");
        step();
        checkOutput("wrap_req",  32'(imem_req), 32'd1);
        checkOutput("wrap_addr", imem_addr,     32'h0);

        // Randomized run checked against the model every cycle.
        useRandData = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            applyStimulus();
        end
        rst = 0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
